// File: rtl/video_timing_rx.sv
// Measures incoming video timing (line/frame geometry, sync polarity) from a
// core's sync/blank outputs, tracks pixel position and reports a timing lock.
module video_timing_rx (
    input  logic        clk_video,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        hblank,
    input  logic        vblank,
    output logic [10:0] h_total,
    output logic [10:0] h_active,
    output logic [9:0]  v_total,
    output logic [9:0]  v_active,
    output logic        hs_pol,
    output logic        vs_pol,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        de,
    output logic        locked,
    output logic        frame_start
);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    localparam logic [10:0] H_MAX = 11'h7FF;
    localparam logic [9:0]  V_MAX = 10'h3FF;
    localparam logic [11:0] T_MAX = 12'hFFF;

    function automatic logic [10:0] inc11(input logic [10:0] v);
        return (v == H_MAX) ? v : v + 11'd1;
    endfunction

    function automatic logic [9:0] inc10(input logic [9:0] v);
        return (v == V_MAX) ? v : v + 10'd1;
    endfunction

    logic        r_hb, r_vb, r_vpend, r_harmed, r_varmed;
    logic [10:0] r_hcnt, r_acnt, r_hs_hi, r_hs_lo;
    logic [9:0]  r_vcnt, r_vact, r_vs_hi, r_vs_lo;
    logic [11:0] r_tcnt;
    logic [10:0] r_snap_ht, r_snap_ha;
    logic [9:0]  r_snap_vt, r_snap_va;
    state_t      r_state, w_next;

    logic w_line_start, w_vfall, w_frame_start;
    logic w_h_valid, w_v_valid, w_f_valid, w_match, w_timeout;

    // Edges compare the live input against the previous ce_pix sample.
    assign w_line_start  = ce_pix & r_hb & ~hblank;
    assign w_vfall       = ce_pix & r_vb & ~vblank;
    assign w_frame_start = w_line_start & (r_vpend | w_vfall);
    assign w_h_valid     = r_harmed & (r_hcnt != H_MAX);
    assign w_v_valid     = r_varmed & (r_vcnt != V_MAX);
    assign w_f_valid     = w_h_valid & w_v_valid;
    assign w_match       = (r_hcnt == r_snap_ht) && (r_acnt == r_snap_ha) &&
                           (r_vcnt == r_snap_vt) && (r_vact == r_snap_va);
    assign w_timeout     = ce_pix & ~w_line_start & (r_tcnt == T_MAX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk_video) begin
        if (reset) begin
            r_hb <= 1'b0;  r_vb <= 1'b0;  r_vpend <= 1'b0;
            r_harmed <= 1'b0;  r_varmed <= 1'b0;
            r_hcnt <= '0;  r_acnt <= '0;  r_hs_hi <= '0;  r_hs_lo <= '0;
            r_vcnt <= '0;  r_vact <= '0;  r_vs_hi <= '0;  r_vs_lo <= '0;
            r_tcnt <= '0;
            r_snap_ht <= '0;  r_snap_ha <= '0;  r_snap_vt <= '0;  r_snap_va <= '0;
            h_total <= '0;  h_active <= '0;  v_total <= '0;  v_active <= '0;
            hs_pol <= 1'b0;  vs_pol <= 1'b0;
            x <= '0;  y <= '0;  de <= 1'b0;  frame_start <= 1'b0;
        end else begin
            frame_start <= w_frame_start;
            if (ce_pix) begin
                r_hb <= hblank;
                r_vb <= vblank;
                de   <= ~hblank & ~vblank;
                if (w_line_start) begin
                    r_harmed <= 1'b1;
                    r_hcnt   <= 11'd1;
                    r_acnt   <= 11'd1;
                    r_tcnt   <= '0;
                    r_hs_hi  <= {10'd0, hsync};
                    r_hs_lo  <= {10'd0, ~hsync};
                    r_vpend  <= 1'b0;
                    x        <= '0;
                    if (w_h_valid) begin
                        h_total  <= r_hcnt;
                        h_active <= r_acnt;
                    end
                    if (r_harmed) hs_pol <= (r_hs_hi < r_hs_lo);
                    if (w_frame_start) begin
                        r_varmed <= 1'b1;
                        r_vcnt   <= 10'd1;
                        r_vact   <= {9'd0, ~vblank};
                        r_vs_hi  <= {9'd0, vsync};
                        r_vs_lo  <= {9'd0, ~vsync};
                        y        <= '0;
                        if (w_v_valid) begin
                            v_total  <= r_vcnt;
                            v_active <= r_vact;
                        end
                        if (r_varmed) vs_pol <= (r_vs_hi < r_vs_lo);
                        // A matching frame reloads identical values, so no match test here.
                        if (w_f_valid && r_state != LOCKED) begin
                            r_snap_ht <= r_hcnt;
                            r_snap_ha <= r_acnt;
                            r_snap_vt <= r_vcnt;
                            r_snap_va <= r_vact;
                        end
                    end else begin
                        r_vcnt  <= inc10(r_vcnt);
                        r_vact  <= vblank ? r_vact : inc10(r_vact);
                        r_vs_hi <= vsync ? inc10(r_vs_hi) : r_vs_hi;
                        r_vs_lo <= vsync ? r_vs_lo : inc10(r_vs_lo);
                        y       <= inc10(y);
                    end
                end else begin
                    r_hcnt  <= inc11(r_hcnt);
                    r_acnt  <= hblank ? r_acnt : inc11(r_acnt);
                    x       <= hblank ? x : inc11(x);
                    r_hs_hi <= hsync ? inc11(r_hs_hi) : r_hs_hi;
                    r_hs_lo <= hsync ? r_hs_lo : inc11(r_hs_lo);
                    r_tcnt  <= (r_tcnt == T_MAX) ? r_tcnt : r_tcnt + 12'd1;
                    if (w_vfall) r_vpend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) r_state <= SEARCH;
        else       r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            SEARCH: if (w_frame_start && w_f_valid) w_next = CHECK;
            CHECK: begin
                if (w_frame_start) begin
                    if (!w_f_valid)   w_next = SEARCH;
                    else if (w_match) w_next = LOCKED;
                end
            end
            LOCKED: begin
                if (w_line_start && (!w_h_valid || r_hcnt != r_snap_ht))
                    w_next = SEARCH;
                else if (w_frame_start && !(w_f_valid && w_match))
                    w_next = SEARCH;
            end
            default: w_next = SEARCH;
        endcase
        if (w_timeout) w_next = SEARCH;
    end

    always_comb begin
        locked = (r_state == LOCKED);
    end

endmodule

// File: doc/video_timing_rx.md
VIDEO_TIMING_RX -- requirements
Module: video_timing_rx

Interface
REQ-001: clk_video  in  1  video clock; all logic on its rising edge.
REQ-002: reset  in  1  synchronous, active-high reset.
REQ-003: ce_pix  in  1  pixel enable; all sampling and counting happen only on cycles with ce_pix=1.
REQ-004: hsync, vsync  in  1 each  core sync outputs, polarity unknown.
REQ-005: hblank, vblank  in  1 each  core blanking outputs, active-high.
REQ-006: h_total  out  11  ce_pix cycles per line, last measured.
REQ-007: h_active  out  11  ce_pix cycles with hblank=0 per line.
REQ-008: v_total  out  10  lines per frame.
REQ-009: v_active  out  10  lines per frame with vblank=0 at line start.
REQ-010: hs_pol, vs_pol  out  1 each  detected sync polarity, 1 = active-high.
REQ-011: x  out  11  pixel column within active line.
REQ-012: y  out  10  line index within frame.
REQ-013: de  out  1  registered ~hblank & ~vblank.
REQ-014: locked  out  1  timing stable.
REQ-015: frame_start  out  1  one-clk pulse at each frame boundary.

Function
REQ-016: Inputs SHALL be registered once; edges SHALL be detected between consecutive ce_pix samples.
REQ-017: Line start SHALL be an hblank 1->0 edge; frame start SHALL be a vblank 1->0 edge seen at or before the next line start.
REQ-018: The line counter SHALL count ce_pix cycles from one line start to the next. At each line start, h_total SHALL take the count and h_active SHALL take the count of hblank=0 samples, both one clk after the ce_pix edge cycle.
REQ-019: hs_pol SHALL update at each line start to 1 if hsync=1 samples < hsync=0 samples over the line, else 0. vs_pol SHALL use the same rule per frame, counting vsync per line start.
REQ-020: v_total and v_active SHALL update at frame start with the line counts of the completed frame. The frame-start line SHALL be line 0 of the new frame.
REQ-021: Simultaneous hblank and vblank falling edges SHALL be processed as both a line start and a frame start in the same cycle.
REQ-022: x SHALL be 0 at line start and increment per ce_pix while hblank=0, saturating at 2047. y SHALL be 0 at frame start and increment at each line start, saturating at 1023.
REQ-023: The horizontal counter SHALL saturate at 2047 and the line counter at 1023. A saturated measurement SHALL be flagged invalid and not copied to outputs.
REQ-024: The lock FSM SHALL have the states SEARCH, CHECK, LOCKED.
- SEARCH -> CHECK at the first frame start with valid measurements; this snapshot is stored.
- CHECK -> LOCKED when the next frame's h_total, h_active, v_total and v_active all equal the snapshot; otherwise stay in CHECK with a new snapshot.
- LOCKED -> SEARCH on any mismatching or invalid frame, or any line whose h_total differs from the snapshot.
- locked=1 only in LOCKED.
REQ-025: Timeout: if no line start occurs for 4096 ce_pix cycles, the FSM SHALL go to SEARCH and measurement outputs SHALL hold their last values.
REQ-026: frame_start SHALL pulse one clk after the ce_pix cycle that detects the frame edge.
REQ-027: ce_pix=0 SHALL freeze all counters and the FSM, except the output pulse clear.

Reset
REQ-028: On reset all outputs SHALL be 0, the FSM SHALL be in SEARCH, and all counters, snapshots and edge registers SHALL be 0.
REQ-029: Reset asserted mid-line or mid-frame SHALL discard partial counts. The first line start after reset only arms the measurement; the first h_total SHALL come from the second line start.
REQ-030: Reset SHALL take priority over ce_pix and all events in the same cycle.

Verification
REQ-031: ce_pix every cycle; line = 16 cycles (hblank=0 for 10, hsync=1 for 2); frame = 8 lines (vblank=0 for 6, vsync=1 for 1 line) -> h_total=16, h_active=10, v_total=8, v_active=6, hs_pol=1, vs_pol=1, locked=1 after the third frame start.
REQ-032: Same timing with hsync and vsync inverted -> hs_pol=0, vs_pol=0, totals unchanged, locked=1.
REQ-033: ce_pix=1 every third cycle, same pattern -> identical measurements. x reaches 9 then holds, y runs 0..7, de matches ~hblank&~vblank delayed one sample.
REQ-034: While locked, one line stretched to 17 cycles -> locked=0 within one clk of that line start, then relock after two good frames.
REQ-035: hblank held 1 for 5000 ce_pix cycles while locked -> locked=0 at cycle 4096, h_total holds 16.
REQ-036: Reset asserted at line 3 pixel 5 -> all outputs 0 next clk. After release, the first h_total update (16) occurs at the second line start.
